// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and parameter defaults for the traffic mode arbiter
package traffic_pkg;

    localparam int VIP_MIN_DEF   = 30;
    localparam int VIP_MAX_DEF   = 60;
    localparam int COOLDOWN_DEF  = 10;
    localparam int NIGHT_DEB_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NORMAL = 2'd1,
        ST_VIP    = 2'd2,
        ST_NIGHT  = 2'd3
    } state_t;

    function automatic logic [1:0] path_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/traffic_mode_arbiter_if.sv
// rtl/traffic_mode_arbiter_if.sv - request/sensor inputs and mode outputs of the arbiter
interface traffic_mode_arbiter_if;

    logic [1:0] vip_req;
    logic       night_sensor;
    logic       start;
    logic       isvip;
    logic       vip_path_index;
    logic       isnight;
    logic [1:0] vip_ack;
    logic [1:0] mode;

    modport master (
        output vip_req, night_sensor,
        input  start, isvip, vip_path_index, isnight, vip_ack, mode
    );

    modport slave (
        input  vip_req, night_sensor,
        output start, isvip, vip_path_index, isnight, vip_ack, mode
    );

endinterface

// File: rtl/night_debounce.sv
// rtl/night_debounce.sv - 2-flop synchronizer followed by a consecutive-cycle debouncer
module night_debounce #(
    parameter int NIGHT_DEB = traffic_pkg::NIGHT_DEB_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(NIGHT_DEB) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIGHT_DEB - 1);

    logic          sync1_q, sync2_q;
    logic          ok_q, ok_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input agrees with the output restarts the run.
    always_comb begin
        ok_d  = ok_q;
        cnt_d = '0;
        if (sync2_q != ok_q) begin
            if (cnt_q >= CNT_LAST) begin
                ok_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ok_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            ok_q    <= ok_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = ok_q;

endmodule

// File: rtl/traffic_mode_arbiter.sv
// rtl/traffic_mode_arbiter.sv - IDLE/NORMAL/VIP/NIGHT mode FSM with round-robin VIP grants
module traffic_mode_arbiter
    import traffic_pkg::*;
#(
    parameter int VIP_MIN   = VIP_MIN_DEF,
    parameter int VIP_MAX   = VIP_MAX_DEF,
    parameter int COOLDOWN  = COOLDOWN_DEF,
    parameter int NIGHT_DEB = NIGHT_DEB_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_mode_arbiter_if.slave  bus
);

    localparam int HW  = $clog2(VIP_MAX) + 1;
    localparam int CDW = $clog2(COOLDOWN) + 1;
    localparam logic [HW-1:0]  MIN_M1   = HW'(VIP_MIN - 1);
    localparam logic [HW-1:0]  MAX_M1   = HW'(VIP_MAX - 1);
    localparam logic [CDW-1:0] CD_LOAD  = CDW'(COOLDOWN);

    state_t         state_q, state_d;
    logic           path_q, path_d;
    logic           rr_q, rr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [CDW-1:0] cd_q, cd_d, cd_dec;
    logic           night_ok;
    logic           pick;
    logic           vip_ok;

    night_debounce #(.NIGHT_DEB(NIGHT_DEB)) u_night (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.night_sensor),
        .dout (night_ok)
    );

    assign cd_dec = (cd_q != '0) ? cd_q - CDW'(1) : '0;
    assign pick   = (bus.vip_req == 2'b11) ? ~rr_q : bus.vip_req[1];
    // The grant starts on the same edge the cooldown expires, giving exactly COOLDOWN idle cycles.
    assign vip_ok = (bus.vip_req != 2'b00) && (cd_dec == '0);

    always_comb begin
        state_d = state_q;
        path_d  = path_q;
        rr_d    = rr_q;
        hold_d  = '0;
        cd_d    = cd_dec;
        case (state_q)
            ST_IDLE: state_d = ST_NORMAL;
            ST_NORMAL, ST_NIGHT: begin
                if (vip_ok) begin
                    state_d = ST_VIP;
                    path_d  = pick;
                    rr_d    = pick;
                end else if (night_ok) begin
                    state_d = ST_NIGHT;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_VIP: begin
                if ((hold_q >= MIN_M1 && !bus.vip_req[path_q]) || hold_q >= MAX_M1) begin
                    state_d = night_ok ? ST_NIGHT : ST_NORMAL;
                    cd_d    = CD_LOAD;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            path_q  <= 1'b0;
            rr_q    <= 1'b1;
            hold_q  <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            cd_q    <= cd_d;
        end
    end

    assign bus.start          = (state_q != ST_IDLE);
    assign bus.isvip          = (state_q == ST_VIP);
    assign bus.isnight        = (state_q == ST_NIGHT);
    assign bus.vip_path_index = path_q;
    assign bus.vip_ack        = (state_q == ST_VIP) ? path_onehot(path_q) : 2'b00;
    assign bus.mode           = state_q;

endmodule

// File: tb/tb_traffic_mode_arbiter.sv
// tb/tb_traffic_mode_arbiter.sv - directed vector table plus multi-cycle sequences for the arbiter
module tb_traffic_mode_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_mode_arbiter_if bus ();

    traffic_mode_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       ns;
        logic [1:0] mode;
        logic       isvip;
        logic       path;
        logic [1:0] ack;
        logic       isnight;
        logic       start;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.vip_req = 2'b00;
        bus.night_sensor = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_isvip(input logic val, input int limit, output int n);
        n = 0;
        while (bus.isvip !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    int  n;
    int  len;
    logic saw;

    initial begin
        bus.vip_req = 2'b00;
        bus.night_sensor = 1'b0;

        //         rst   req    ns    mode  vip   path  ack    night start
        vecs[0] = '{1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b11, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst;
            bus.vip_req = vecs[i].req;
            bus.night_sensor = vecs[i].ns;
            tick();
            chk($sformatf("v%0d_mode", i),    int'(bus.mode),           int'(vecs[i].mode));
            chk($sformatf("v%0d_isvip", i),   int'(bus.isvip),          int'(vecs[i].isvip));
            chk($sformatf("v%0d_path", i),    int'(bus.vip_path_index), int'(vecs[i].path));
            chk($sformatf("v%0d_ack", i),     int'(bus.vip_ack),        int'(vecs[i].ack));
            chk($sformatf("v%0d_isnight", i), int'(bus.isnight),        int'(vecs[i].isnight));
            chk($sformatf("v%0d_start", i),   int'(bus.start),          int'(vecs[i].start));
        end

        // Long single request: forced release at VIP_MAX, cooldown, re-grant
        do_reset();
        bus.vip_req = 2'b01;
        tick();
        chk("single_first_isvip", int'(bus.isvip), 1);
        chk("single_first_path", int'(bus.vip_path_index), 0);
        wait_isvip(1'b0, 200, n);
        chk("single_grant_len", n, 60);
        chk("single_after_mode", int'(bus.mode), 1);
        wait_isvip(1'b1, 200, n);
        chk("single_cooldown_len", n, 10);
        chk("single_regrant_path", int'(bus.vip_path_index), 0);
        chk("single_regrant_ack", int'(bus.vip_ack), 1);

        // Short request on path 1 still runs to VIP_MIN
        do_reset();
        bus.vip_req = 2'b10;
        tick();
        chk("short_isvip", int'(bus.isvip), 1);
        chk("short_ack", int'(bus.vip_ack), 2);
        chk("short_path", int'(bus.vip_path_index), 1);
        len = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            len += int'(bus.isvip);
        end
        bus.vip_req = 2'b00;
        wait_isvip(1'b0, 200, n);
        len += n - 1;
        chk("short_grant_len", len, 30);

        // Tie after reset: path 0 first, then path 1
        do_reset();
        bus.vip_req = 2'b11;
        tick();
        chk("tie_first_path", int'(bus.vip_path_index), 0);
        wait_isvip(1'b0, 200, n);
        chk("tie_first_len", n, 60);
        wait_isvip(1'b1, 200, n);
        chk("tie_cooldown_len", n, 10);
        chk("tie_second_path", int'(bus.vip_path_index), 1);
        chk("tie_second_ack", int'(bus.vip_ack), 2);

        // 10-cycle night glitch is filtered
        do_reset();
        saw = 1'b0;
        bus.night_sensor = 1'b1;
        repeat (10) begin
            tick();
            if (bus.isnight) saw = 1'b1;
        end
        bus.night_sensor = 1'b0;
        repeat (40) begin
            tick();
            if (bus.isnight) saw = 1'b1;
        end
        chk("glitch_isnight", int'(saw), 0);

        // Steady night, VIP preempts, return to NIGHT
        do_reset();
        bus.night_sensor = 1'b1;
        tick();
        n = 1;
        while (!bus.isnight && n < 100) begin
            tick();
            n++;
        end
        chk("night_latency", n, 19);
        chk("night_mode", int'(bus.mode), 3);
        bus.vip_req = 2'b01;
        tick();
        chk("night_vip_isvip", int'(bus.isvip), 1);
        chk("night_vip_isnight", int'(bus.isnight), 0);
        chk("night_vip_mode", int'(bus.mode), 2);
        bus.vip_req = 2'b00;
        wait_isvip(1'b0, 200, n);
        chk("night_vip_len", n, 30);
        chk("night_return_mode", int'(bus.mode), 3);
        chk("night_return_isnight", int'(bus.isnight), 1);
        do_reset();
        chk("post_reset_mode", int'(bus.mode), 1);
        chk("post_reset_isnight", int'(bus.isnight), 0);

        // Reset in the middle of a path-1 grant
        do_reset();
        bus.vip_req = 2'b10;
        tick();
        repeat (20) tick();
        chk("midvip_pre_mode", int'(bus.mode), 2);
        chk("midvip_pre_path", int'(bus.vip_path_index), 1);
        rst = 1'b1;
        tick();
        chk("midvip_mode", int'(bus.mode), 0);
        chk("midvip_isvip", int'(bus.isvip), 0);
        chk("midvip_path", int'(bus.vip_path_index), 0);
        chk("midvip_ack", int'(bus.vip_ack), 0);
        chk("midvip_start", int'(bus.start), 0);
        chk("midvip_isnight", int'(bus.isnight), 0);
        rst = 1'b0;
        bus.vip_req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
